// File: rtl/step_main_pkg.sv
// Shared constants for the single-step teaching CPU: opcodes, display selects, program ROM.
package step_main_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUBI = 3'b011;
   localparam logic [2:0] OP_ST   = 3'b100;
   localparam logic [2:0] OP_LD   = 3'b101;
   localparam logic [2:0] OP_JZ   = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   localparam logic [2:0] SEL_ACC  = 3'd0;
   localparam logic [2:0] SEL_PC   = 3'd1;
   localparam logic [2:0] SEL_IR   = 3'd2;
   localparam logic [2:0] SEL_FLAG = 3'd3;
   localparam logic [2:0] SEL_R0   = 3'd4;
   localparam logic [2:0] SEL_R1   = 3'd5;
   localparam logic [2:0] SEL_R2   = 3'd6;
   localparam logic [2:0] SEL_CNT  = 3'd7;

   // Count 5 down to 0 in R0/ACC, then park in a self-loop at address 7.
   localparam logic [7:0] ROM [16] = '{
      8'h25, 8'h80, 8'h61, 8'hC5, 8'hE2, 8'h81, 8'h5F, 8'hE7,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

endpackage

// File: rtl/step_main_btn.sv
// Button synchronizer + debouncer producing a one-cycle step pulse per press; pulse lags the pin by ~DEBOUNCE_CYCLES+3.
// AUTO_REPEAT_EN: while held, also pulse every AUTO_PERIOD cycles.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned AUTO_PERIOD     = 25000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic step_o
);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         cnt_q   <= cnt_d;
      end
   end

   assign rise = level_q & ~prev_q;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned PW = $clog2(AUTO_PERIOD + 1);
   logic [PW-1:0] per_q, per_d;
   logic          fire;

   assign fire = level_q & prev_q & (per_q == PW'(AUTO_PERIOD - 1));

   always_comb begin
      per_d = per_q + 1'b1;
      if (!level_q || rise || fire) per_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) per_q <= '0;
      else         per_q <= per_d;
   end

   assign step_o = rise | fire;
`else
   assign step_o = rise;
`endif

endmodule

// File: rtl/step_main.sv
// Board top: 8-bit accumulator CPU stepping through a 16-word ROM once per debounced button press.
// State updates the cycle after the step pulse; LED is the registered SW-selected view one cycle later.
module step_main
   import step_main_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned AUTO_PERIOD     = 25000000
) (
   input  logic       clk_100,
   input  logic       rst,
   input  logic       Step_BTN,
   input  logic [2:0] SW,
   output logic [7:0] LED
);
   logic       step;
   logic [7:0] acc_q, acc_d;
   logic [3:0] pc_q, pc_d;
   logic       z_q, z_d, c_q, c_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] regs_q [8];
   logic       reg_we;
   logic [7:0] led_q, led_d;
   logic [7:0] ir;
   logic [2:0] op;
   logic [4:0] imm;
   logic [8:0] sum;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .AUTO_PERIOD    (AUTO_PERIOD)
   ) u_btn (
      .clk_i (clk_100),
      .rst_ni(rst),
      .btn_i (Step_BTN),
      .step_o(step)
   );

   assign ir  = ROM[pc_q];
   assign op  = ir[7:5];
   assign imm = ir[4:0];
   assign sum = {1'b0, acc_q} + {4'b0, imm};

   always_comb begin
      acc_d  = acc_q;
      pc_d   = pc_q;
      z_d    = z_q;
      c_d    = c_q;
      cnt_d  = cnt_q;
      reg_we = 1'b0;
      if (step) begin
         pc_d  = pc_q + 4'd1;
         cnt_d = cnt_q + 8'd1;
         unique case (op)
            OP_LDI:  acc_d = {3'b0, imm};
            OP_ADDI: {c_d, acc_d} = sum;
            OP_SUBI: begin
               acc_d = acc_q - {3'b0, imm};
               c_d   = acc_q < {3'b0, imm};
            end
            OP_ST:   reg_we = 1'b1;
            OP_LD:   acc_d = regs_q[imm[2:0]];
            OP_JZ:   if (z_q) pc_d = imm[3:0];
            OP_JMP:  pc_d = imm[3:0];
            default: ;
         endcase
         // Z tracks only the instructions that write ACC.
         if (op == OP_LDI || op == OP_ADDI || op == OP_SUBI || op == OP_LD) z_d = (acc_d == 8'd0);
      end
   end

   always_comb begin
      led_d = 8'd0;
      unique case (SW)
         SEL_ACC:  led_d = acc_q;
         SEL_PC:   led_d = {4'b0, pc_q};
         SEL_IR:   led_d = ir;
         SEL_FLAG: led_d = {6'b0, c_q, z_q};
         SEL_R0:   led_d = regs_q[0];
         SEL_R1:   led_d = regs_q[1];
         SEL_R2:   led_d = regs_q[2];
         SEL_CNT:  led_d = cnt_q;
         default:  led_d = 8'd0;
      endcase
   end

   always_ff @(posedge clk_100 or negedge rst) begin
      if (!rst) begin
         acc_q <= 8'd0;
         pc_q  <= 4'd0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         cnt_q <= 8'd0;
         led_q <= 8'd0;
         for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
      end else begin
         acc_q <= acc_d;
         pc_q  <= pc_d;
         z_q   <= z_d;
         c_q   <= c_d;
         cnt_q <= cnt_d;
         led_q <= led_d;
         if (reg_we) regs_q[imm[2:0]] <= acc_q;
      end
   end

   assign LED = led_q;

endmodule

// File: tb/tb_step_main.sv
module tb_step_main;
   logic       clk_100 = 1'b0;
   logic       rst = 1'b0;
   logic       Step_BTN = 1'b0;
   logic [2:0] SW = 3'd0;
   logic [7:0] LED;
   int         nchk = 0;
   int         nerr = 0;

   always #5 clk_100 = ~clk_100;

   step_main #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
      .clk_100 (clk_100),
      .rst     (rst),
      .Step_BTN(Step_BTN),
      .SW      (SW),
      .LED     (LED)
   );

   task automatic rd(input logic [2:0] s, output logic [7:0] v);
      SW = s;
      @(posedge clk_100);
      #1 v = LED;
   endtask

   task automatic press(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_100); #1 Step_BTN = 1'b1;
         repeat (12) @(posedge clk_100);
         #1 Step_BTN = 1'b0;
         repeat (12) @(posedge clk_100);
      end
   endtask

   task automatic test_reset;
      logic [7:0] v;
      rst = 1'b0; SW = 3'd5;
      repeat (10) @(posedge clk_100);
      #1 nchk++;
      if (LED !== 8'h00) begin nerr++; $display("FAIL reset_led: got %h want %h", LED, 8'h00); end
      SW = 3'd2;
      rst = 1'b1;
      rd(3'd2, v); nchk++;
      if (v !== 8'h25) begin nerr++; $display("FAIL reset_ir: got %h want %h", v, 8'h25); end
   endtask

   task automatic test_debounce;
      logic [7:0] v;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_100); #1 Step_BTN = 1'b1;
         repeat (2) @(posedge clk_100);
         #1 Step_BTN = 1'b0;
         repeat (3) @(posedge clk_100);
      end
      repeat (6) @(posedge clk_100);
      rd(3'd1, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL glitch_pc: got %h want %h", v, 8'h00); end
      rd(3'd7, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL glitch_cnt: got %h want %h", v, 8'h00); end
      @(posedge clk_100); #1 Step_BTN = 1'b1;
      repeat (10) @(posedge clk_100);
      #1 Step_BTN = 1'b0;
      repeat (12) @(posedge clk_100);
      rd(3'd1, v); nchk++;
      if (v !== 8'h01) begin nerr++; $display("FAIL press_pc: got %h want %h", v, 8'h01); end
      rd(3'd7, v); nchk++;
      if (v !== 8'h01) begin nerr++; $display("FAIL press_cnt: got %h want %h", v, 8'h01); end
   endtask

   task automatic test_program;
      logic [7:0] v;
      press(1);
      rd(3'd0, v); nchk++;
      if (v !== 8'h05) begin nerr++; $display("FAIL p2_acc: got %h want %h", v, 8'h05); end
      rd(3'd4, v); nchk++;
      if (v !== 8'h05) begin nerr++; $display("FAIL p2_r0: got %h want %h", v, 8'h05); end
      press(1);
      rd(3'd0, v); nchk++;
      if (v !== 8'h04) begin nerr++; $display("FAIL p3_acc: got %h want %h", v, 8'h04); end
      rd(3'd3, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL p3_flags: got %h want %h", v, 8'h00); end
   endtask

   // Five SUBI passes bring ACC to 0 at press 15; the JZ at press 16 lands on PC 5.
   task automatic test_loop;
      logic [7:0] v;
      press(13);
      rd(3'd0, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL loop_acc: got %h want %h", v, 8'h00); end
      rd(3'd3, v); nchk++;
      if (v !== 8'h01) begin nerr++; $display("FAIL loop_flags: got %h want %h", v, 8'h01); end
      rd(3'd1, v); nchk++;
      if (v !== 8'h05) begin nerr++; $display("FAIL loop_pc: got %h want %h", v, 8'h05); end
   endtask

   task automatic test_arith;
      logic [7:0] v;
      press(2);
      rd(3'd1, v); nchk++;
      if (v !== 8'h07) begin nerr++; $display("FAIL arith_pc: got %h want %h", v, 8'h07); end
      rd(3'd5, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL arith_r1: got %h want %h", v, 8'h00); end
      rd(3'd0, v); nchk++;
      if (v !== 8'h1F) begin nerr++; $display("FAIL arith_acc: got %h want %h", v, 8'h1F); end
      rd(3'd3, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL arith_flags: got %h want %h", v, 8'h00); end
      press(2);
      rd(3'd1, v); nchk++;
      if (v !== 8'h07) begin nerr++; $display("FAIL park_pc: got %h want %h", v, 8'h07); end
      rd(3'd7, v); nchk++;
      if (v !== 8'h14) begin nerr++; $display("FAIL park_cnt: got %h want %h", v, 8'h14); end
      rd(3'd2, v); nchk++;
      if (v !== 8'hE7) begin nerr++; $display("FAIL park_ir: got %h want %h", v, 8'hE7); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] v;
      @(posedge clk_100); #2 rst = 1'b0;
      repeat (3) @(posedge clk_100);
      #1 rst = 1'b1;
      press(5);
      rd(3'd7, v); nchk++;
      if (v !== 8'h05) begin nerr++; $display("FAIL mid_cnt5: got %h want %h", v, 8'h05); end
      rd(3'd1, v); nchk++;
      if (v !== 8'h02) begin nerr++; $display("FAIL mid_pc5: got %h want %h", v, 8'h02); end
      @(posedge clk_100); #1 Step_BTN = 1'b1;
      repeat (9) @(posedge clk_100);
      #3 rst = 1'b0;
      #1 nchk++;
      if (LED !== 8'h00) begin nerr++; $display("FAIL mid_async_led: got %h want %h", LED, 8'h00); end
      for (int s = 0; s < 8; s++) begin
         rd(3'(s), v); nchk++;
         if (v !== 8'h00) begin nerr++; $display("FAIL mid_view%0d: got %h want %h", s, v, 8'h00); end
      end
      rst = 1'b1;
      rd(3'd7, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL post_rst_cnt: got %h want %h", v, 8'h00); end
      rd(3'd1, v); nchk++;
      if (v !== 8'h00) begin nerr++; $display("FAIL post_rst_pc: got %h want %h", v, 8'h00); end
      repeat (15) @(posedge clk_100);
      rd(3'd7, v); nchk++;
      if (v !== 8'h01) begin nerr++; $display("FAIL held_edge_cnt: got %h want %h", v, 8'h01); end
      rd(3'd1, v); nchk++;
      if (v !== 8'h01) begin nerr++; $display("FAIL held_edge_pc: got %h want %h", v, 8'h01); end
      #1 Step_BTN = 1'b0;
      repeat (12) @(posedge clk_100);
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_program();
      test_loop();
      test_arith();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
